// File: rtl/lif_neuron_array_if.sv
// -----------------------------------------------------------------------------
// lif_neuron_array_if
//
// Bundle of the neuron array's data and configuration signals.
//
//   master : drives ena, I_syn, v_th, v_reset, leak_shift, refrac, clr_cnt;
//            observes V_mem, spike, spike_cnt
//   slave  : the neuron array itself (mirror image of master)
//
// Signals:
//   ena         update enable; low freezes every channel
//   I_syn       packed synaptic inputs, channel k at [k*WIDTH +: WIDTH]
//   v_th        shared firing threshold
//   v_reset     membrane value loaded on a spike and during refractory time
//   leak_shift  leak divisor exponent, 0 disables the leak
//   refrac      refractory length in enabled cycles, taken at the spike
//   clr_cnt     synchronous clear of all spike counters
//   V_mem       packed registered membrane potentials
//   spike       registered one-cycle spike pulses
//   spike_cnt   packed wrap-around spike counters
// -----------------------------------------------------------------------------
interface lif_neuron_array_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int RW    = 4,
  parameter int CW    = 8
);

  logic                    ena;
  logic [N_CH*WIDTH-1:0]   I_syn;
  logic [WIDTH-1:0]        v_th;
  logic [WIDTH-1:0]        v_reset;
  logic [2:0]              leak_shift;
  logic [RW-1:0]           refrac;
  logic                    clr_cnt;
  logic [N_CH*WIDTH-1:0]   V_mem;
  logic [N_CH-1:0]         spike;
  logic [N_CH*CW-1:0]      spike_cnt;

  modport master (
    output ena, I_syn, v_th, v_reset, leak_shift, refrac, clr_cnt,
    input  V_mem, spike, spike_cnt
  );

  modport slave (
    input  ena, I_syn, v_th, v_reset, leak_shift, refrac, clr_cnt,
    output V_mem, spike, spike_cnt
  );

endinterface

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
//
// N_CH independent leaky integrate-and-fire neurons. Every enabled cycle each
// channel either integrates (shift leak, add synaptic input, saturate, compare
// against threshold) or sits out a refractory period after a spike. Channels
// share only the configuration inputs carried on the interface.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset; returns every channel to INTEG
//          with V_mem, spike, spike_cnt and the refractory count at zero
//   bus    lif_neuron_array_if.slave (inputs/outputs listed in the interface)
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module lif_neuron_array #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int RW    = 4,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  lif_neuron_array_if.slave  bus
);

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] V_MAX = {WIDTH{1'b1}};

  for (genvar k = 0; k < N_CH; k++) begin : g_ch

    // -------------------------------------------------------------------------
    // Per-channel state
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [WIDTH-1:0] v_q,    v_d;
    logic [RW-1:0]    rc_q,   rc_d;
    logic             spike_q, spike_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    // -------------------------------------------------------------------------
    // Integration datapath
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] i_syn;
    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] v_next;
    logic             fire;

    assign i_syn = bus.I_syn[k*WIDTH +: WIDTH];

    always_comb begin
      // A shift by zero would return V itself, so zero is special-cased to
      // mean "no leak" rather than "leak everything".
      leak   = (bus.leak_shift == 3'd0) ? '0 : (v_q >> bus.leak_shift);
      // leak <= v_q, so the subtraction cannot borrow; the extra top bit only
      // ever catches the carry of the addition.
      sum    = {1'b0, v_q} - {1'b0, leak} + {1'b0, i_syn};
      v_next = sum[WIDTH] ? V_MAX : sum[WIDTH-1:0];
      fire   = bus.ena && (state_q == INTEG) && (v_next >= bus.v_th);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= INTEG;
        v_q     <= '0;
        rc_q    <= '0;
        spike_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        v_q     <= v_d;
        rc_q    <= rc_d;
        spike_q <= spike_d;
        cnt_q   <= cnt_d;
      end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
      state_d = state_q;
      if (bus.ena) begin
        unique case (state_q)
          INTEG: begin
            // A zero refractory length lets the channel fire again on the very
            // next enabled cycle, so it never enters REFRAC.
            if (fire && (bus.refrac != '0)) state_d = REFRAC;
          end
          REFRAC: begin
            // rc counts the refractory cycles still to go, including this one.
            if (rc_q <= RW'(1)) state_d = INTEG;
          end
          default: state_d = INTEG;
        endcase
      end
    end

    // -------------------------------------------------------------------------
    // Output / datapath register inputs
    // -------------------------------------------------------------------------
    always_comb begin
      v_d     = v_q;
      rc_d    = rc_q;
      spike_d = 1'b0;
      cnt_d   = cnt_q;
      if (bus.ena) begin
        unique case (state_q)
          INTEG: begin
            if (fire) begin
              spike_d = 1'b1;
              v_d     = bus.v_reset;
              // refrac is captured only here, so later changes do not disturb
              // a refractory period already under way.
              rc_d    = bus.refrac;
            end else begin
              v_d     = v_next;
            end
          end
          REFRAC: begin
            v_d  = bus.v_reset;
            rc_d = rc_q - RW'(1);
          end
          default: ;
        endcase

        // Clear first, then count, so a clear coinciding with a spike leaves 1.
        if (bus.clr_cnt) cnt_d = '0;
        if (fire)        cnt_d = cnt_d + CW'(1);
      end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.V_mem[k*WIDTH +: WIDTH] = v_q;
    assign bus.spike[k]                = spike_q;
    assign bus.spike_cnt[k*CW +: CW]   = cnt_q;

  end : g_ch

endmodule

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array
//
// Scoreboard bench: a driver process applies one set of inputs per cycle on
// the falling edge, steps a behavioural neuron model and queues the expected
// outputs; a monitor process compares every queued entry with the DUT just
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_lif_neuron_array;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int RW    = 4;
  localparam int CW    = 8;
  localparam int V_MAX = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lif_neuron_array_if #(.N_CH(N_CH), .WIDTH(WIDTH), .RW(RW), .CW(CW)) bus ();

  lif_neuron_array #(.N_CH(N_CH), .WIDTH(WIDTH), .RW(RW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N_CH*WIDTH-1:0] v;
    logic [N_CH-1:0]       s;
    logic [N_CH*CW-1:0]    c;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus knobs (applied to the DUT by tick())
  // ---------------------------------------------------------------------------
  bit c_rst;
  bit c_ena;
  bit c_clr;
  int c_isyn [N_CH];
  int c_vth, c_vreset, c_ls, c_rf;

  // ---------------------------------------------------------------------------
  // Reference model: membrane value, remaining refractory cycles, spike count
  // ---------------------------------------------------------------------------
  int m_v   [N_CH];
  int m_rem [N_CH];
  int m_cnt [N_CH];

  task automatic model_step();
    exp_t e;
    e.v = '0;
    e.s = '0;
    e.c = '0;
    for (int k = 0; k < N_CH; k++) begin
      bit spk;
      spk = 1'b0;
      if (c_rst) begin
        m_v[k]   = 0;
        m_rem[k] = 0;
        m_cnt[k] = 0;
      end else if (c_ena) begin
        if (m_rem[k] > 0) begin
          m_v[k] = c_vreset;
          m_rem[k]--;
        end else begin
          int leak, s;
          leak = (c_ls == 0) ? 0 : (m_v[k] / (1 << c_ls));
          s    = m_v[k] - leak + c_isyn[k];
          if (s > V_MAX) s = V_MAX;
          if (s >= c_vth) begin
            spk      = 1'b1;
            m_v[k]   = c_vreset;
            m_rem[k] = c_rf;
          end else begin
            m_v[k] = s;
          end
        end
        if (c_clr) m_cnt[k] = 0;
        if (spk)   m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
      end
      e.v[k*WIDTH +: WIDTH] = WIDTH'(m_v[k]);
      e.s[k]                = spk;
      e.c[k*CW +: CW]       = CW'(m_cnt[k]);
    end
    sb_q.push_back(e);
  endtask

  // One cycle: apply knobs on the falling edge, predict the next rising edge.
  task automatic tick();
    logic [N_CH*WIDTH-1:0] isyn;
    @(negedge clk);
    for (int k = 0; k < N_CH; k++) isyn[k*WIDTH +: WIDTH] = WIDTH'(c_isyn[k]);
    reset          = c_rst;
    bus.ena        = c_ena;
    bus.clr_cnt    = c_clr;
    bus.I_syn      = isyn;
    bus.v_th       = WIDTH'(c_vth);
    bus.v_reset    = WIDTH'(c_vreset);
    bus.leak_shift = 3'(c_ls);
    bus.refrac     = RW'(c_rf);
    model_step();
  endtask

  task automatic set_all_isyn(input int val);
    for (int k = 0; k < N_CH; k++) c_isyn[k] = val;
  endtask

  task automatic do_reset();
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("v_mem",     64'(bus.V_mem),     64'(e.v));
        check("spike",     64'(bus.spike),     64'(e.s));
        check("spike_cnt", 64'(bus.spike_cnt), 64'(e.c));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    reset          = 1'b1;
    bus.ena        = 1'b0;
    bus.clr_cnt    = 1'b0;
    bus.I_syn      = '0;
    bus.v_th       = '0;
    bus.v_reset    = '0;
    bus.leak_shift = '0;
    bus.refrac     = '0;
    c_ena = 1'b1; c_clr = 1'b0;
    c_vth = 255; c_vreset = 0; c_ls = 0; c_rf = 0;
    set_all_isyn(0);

    // Reset state
    do_reset();
    #1;
    check("reset_v_mem",     64'(bus.V_mem),     64'd0);
    check("reset_spike",     64'(bus.spike),     64'd0);
    check("reset_spike_cnt", 64'(bus.spike_cnt), 64'd0);

    // Integrate without leak: 30, 60, 90, spike, 30
    c_ls = 0; c_vth = 100; c_rf = 0; c_vreset = 0;
    set_all_isyn(30);
    run(6);

    // Leak: converges near 61..64 without firing
    do_reset();
    c_ls = 2; c_vth = 255; set_all_isyn(16);
    run(25);

    // Saturation: 200, then 400 saturates to 255 >= 255 and fires
    do_reset();
    c_ls = 0; c_vth = 255; c_vreset = 7; set_all_isyn(200);
    run(4);

    // Refractory: spikes every 4 cycles with refrac=3
    do_reset();
    c_rf = 3; c_vth = 50; c_vreset = 5; set_all_isyn(60);
    run(10);

    // ena dropped mid-refractory, with refrac changed meanwhile
    do_reset();
    run(2);
    c_ena = 1'b0; c_rf = 9;
    run(5);
    c_ena = 1'b1;
    run(8);
    c_rf = 3;

    // clr_cnt in a spike cycle: every cycle fires with v_th=0, refrac=0
    do_reset();
    c_vth = 0; c_rf = 0;
    run(5);
    c_clr = 1'b1;
    run(1);
    c_clr = 1'b0;
    run(2);

    // Counter wrap: 256 spikes bring spike_cnt back to 0
    do_reset();
    run(258);

    // Asynchronous reset in the middle of a refractory period
    do_reset();
    c_rf = 5; c_vth = 50; c_vreset = 9; set_all_isyn(60);
    run(3);
    do_reset();
    #1;
    check("async_rst_v_mem",     64'(bus.V_mem),     64'd0);
    check("async_rst_spike",     64'(bus.spike),     64'd0);
    check("async_rst_spike_cnt", 64'(bus.spike_cnt), 64'd0);
    run(3);

    // Channel independence: first spikes at cycles 8, 4, 2, 1
    do_reset();
    c_ls = 0; c_rf = 0; c_vth = 80; c_vreset = 0;
    c_isyn[0] = 10; c_isyn[1] = 20; c_isyn[2] = 40; c_isyn[3] = 80;
    run(10);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      c_ena    = ($urandom_range(0, 9) != 0);
      c_clr    = ($urandom_range(0, 19) == 0);
      c_rst    = ($urandom_range(0, 99) == 0);
      c_vth    = (i % 100 < 10) ? 0 : int'($urandom_range(0, V_MAX));
      c_vreset = $urandom_range(0, 40);
      c_ls     = $urandom_range(0, 7);
      c_rf     = $urandom_range(0, (1 << RW) - 1);
      for (int k = 0; k < N_CH; k++) c_isyn[k] = $urandom_range(0, V_MAX);
      tick();
    end
    c_rst = 1'b0;
    c_ena = 1'b1;
    c_clr = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of N_CH independent leaky integrate-and-fire neurons: the multi-channel successor of the single 8-bit membrane decoder. Each channel integrates its synaptic input I_syn, applies a programmable shift leak, fires a one-cycle spike on threshold crossing, then holds through a programmable refractory period. It sits behind the top-level pin wrapper. Channel 0's V_mem drives uo_out, and the spike vector and counters are available for uio_out.

## Interface
- N_CH, 4, number of neuron channels
- WIDTH, 8, membrane and synaptic-input width in bits
- RW, 4, refractory counter width in bits
- CW, 8, per-channel spike counter width in bits

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ena  in  1  update enable; when low, all state holds
- I_syn  in  N_CH*WIDTH  packed synaptic inputs, channel k at [k*WIDTH +: WIDTH]
- v_th  in  WIDTH  firing threshold, shared by all channels
- v_reset  in  WIDTH  post-spike membrane value
- leak_shift  in  3  leak divisor exponent; 0 means no leak
- refrac  in  RW  refractory length in enabled cycles
- clr_cnt  in  1  synchronous clear of all spike counters
- V_mem  out  N_CH*WIDTH  packed registered membrane potentials
- spike  out  N_CH  registered one-cycle spike pulses
- spike_cnt  out  N_CH*CW  packed spike counters, wrap-around

## Operation
- Each channel is one FSM with two states, INTEG and REFRAC. Channels share only the configuration inputs.
- INTEG, with ena=1:
  - leak = (leak_shift==0) ? 0 : V >> leak_shift
  - sum = V − leak + I_syn, computed at WIDTH+1 bits
  - Vn = sum saturated to 2^WIDTH−1. Vn cannot underflow because leak ≤ V.
  - If Vn ≥ v_th: spike←1, V←v_reset, rc←refrac. Go to REFRAC if refrac≠0, else stay in INTEG.
  - Otherwise: V←Vn, spike←0.
- REFRAC, with ena=1:
  - I_syn is ignored, V←v_reset, spike←0, rc←rc−1.
  - When rc reaches 1, the next state is INTEG.
  - A refractory period therefore lasts exactly refrac enabled cycles.
- ena=0: V, state, rc and spike_cnt hold, and spike←0.
- v_th=0: every INTEG cycle fires.
- Configuration inputs are sampled every cycle, except that refrac is sampled only at the spike cycle. A mid-period change of refrac does not alter the running count.
- spike_cnt[k] increments by 1 on each spike of channel k and wraps from 2^CW−1 to 0.
- clr_cnt=1 zeroes the counter. If a spike occurs in the same cycle, the counter becomes 1: clear first, then increment.
- Reset, asynchronous, from any state:
  - V_mem=0, spike=0, spike_cnt=0
  - state=INTEG, rc=0

## Timing
- All outputs are registered. No combinational path exists from input to output.
- Latency: I_syn sampled at edge t is reflected in V_mem and spike after edge t.
- The spike pulse is exactly one clk cycle wide. V_mem shows v_reset in the same cycle that spike=1.
- Minimum spike interval per channel is refrac+1 enabled cycles.
- Deassertion of reset is not synchronised internally. The wrapper guarantees reset is released away from a clk edge.
- Reset asserted mid-refractory or mid-integration clears state immediately. The first integration happens on the first enabled edge after release.

## Test plan
- **Integrate, no leak.** WIDTH=8, leak_shift=0, v_th=100, refrac=0, I_syn[0]=30. Required: V_mem0 goes 30, 60, 90, then spike on the 4th cycle with V_mem0=v_reset=0, and spike_cnt0=1. V_mem0 is 30 again on the 5th cycle.
- **Leak.** leak_shift=2, I_syn=16, v_th=255. Required: V goes 16, 28, 37, 44, …, converging to 61–64 with no spike.
- **Saturation and threshold.** v_th=255, I_syn=200. Required: cycle 1 V=200, cycle 2 sum 400 saturates to 255 ≥ 255, so spike with V=v_reset.
- **Refractory.** refrac=3, v_th=50, I_syn=60. Required: spike at cycles 1, 5, 9. Between spikes V_mem=v_reset and spike=0 for 3 cycles.
- **ena and clr_cnt.**
  - Drop ena for 5 cycles mid-refractory. Required: V, rc and spike_cnt hold, and the refractory period still lasts 3 enabled cycles.
  - Drive clr_cnt in a spike cycle. Required: spike_cnt=1.
  - With CW=8, 256 spikes. Required: spike_cnt wraps to 0.
- **Async reset and channel independence.**
  - Assert reset between edges during REFRAC. Required: V_mem, spike and spike_cnt go to 0 before the next edge.
  - Drive 4 channels with I_syn=10, 20, 40, 80 and v_th=80. Required: first spikes at cycles 8, 4, 2, 1 respectively.
